// File: rtl/bus_copy_engine.sv
// Bus-master block copy: reads a word from src, writes it to dst, repeats `length` times.
// Bus data returns one cycle after the read address, so every word is READ, CAPTURE, WRITE.
module bus_copy_engine #(
    parameter int unsigned address_width = 16,
    parameter int unsigned data_width    = 8,
    parameter int unsigned len_width     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [address_width-1:0] src_addr,
    input  logic [address_width-1:0] dst_addr,
    input  logic [len_width-1:0]     length,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [len_width-1:0]     words_done,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic [address_width-1:0] bus_addr,
    output logic                     bus_wr,
    output logic [data_width-1:0]    bus_dout,
    input  logic [data_width-1:0]    bus_din
);

    localparam logic [address_width-1:0] AddrOne = address_width'(1);
    localparam logic [len_width-1:0]     LenOne  = len_width'(1);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StWrite, StFin} state_e;

    state_e                   state_q, state_d;
    logic [address_width-1:0] src_ptr_q, src_ptr_d;
    logic [address_width-1:0] dst_ptr_q, dst_ptr_d;
    logic [len_width-1:0]     remaining_q, remaining_d;
    logic [len_width-1:0]     words_done_q, words_done_d;
    logic [data_width-1:0]    data_q, data_d;
    logic                     aborted_q, aborted_d;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            data_q       <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            data_q       <= data_d;
            aborted_q    <= aborted_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        data_d       = data_q;
        aborted_d    = aborted_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    remaining_d  = length;
                    words_done_d = '0;
                    aborted_d    = 1'b0;
                    state_d      = (length == '0) ? StFin : StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (bus_gnt) begin
                    src_ptr_d = src_ptr_q + AddrOne;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                data_d = bus_din;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // A granted write commits even when abort arrives in the same cycle.
                if (bus_gnt) begin
                    dst_ptr_d    = dst_ptr_q + AddrOne;
                    words_done_d = words_done_q + LenOne;
                    remaining_d  = remaining_q - LenOne;
                    if (abort) begin
                        aborted_d = 1'b1;
                        state_d   = StIdle;
                    end else if (remaining_q == LenOne) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRead;
                    end
                end else if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy       = (state_q != StIdle);
        done       = (state_q == StFin);
        aborted    = aborted_q;
        words_done = words_done_q;
        bus_req    = 1'b0;
        bus_addr   = '0;
        bus_wr     = 1'b0;
        bus_dout   = '0;
        case (state_q)
            StRead: begin
                bus_req  = 1'b1;
                bus_addr = src_ptr_q;
            end
            StCapture: begin
                // Pointer already advanced on the granted read; show the address just read.
                bus_req  = 1'b1;
                bus_addr = src_ptr_q - AddrOne;
            end
            StWrite: begin
                bus_req  = 1'b1;
                bus_addr = dst_ptr_q;
                bus_wr   = 1'b1;
                bus_dout = data_q;
            end
            default: ;
        endcase
    end

endmodule
